// File: rtl/mc_ctrl_pkg.sv
// Shared control encodings for the multi-cycle MIPS-subset controller: states,
// ALU operation codes, opcode/funct values and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
`else
        S_JUMP     = 4'd10
`endif
    } state_t;

    localparam logic [4:0] ALU_ADDU = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUBU = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_EQL  = 5'd10;
    localparam logic [4:0] ALU_BNE  = 5'd11;
    localparam logic [4:0] ALU_GT0  = 5'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// mc_alu_dec: combinational map of (state, op, funct) to ALU operation code,
// immediate extension mode and an illegal-instruction flag.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [4:0] o_alu_op,
    output logic       o_ext_op,
    output logic       o_illegal
);

    logic [4:0] w_rAluOp;
    logic       w_rLegal;

    always_comb begin
        w_rAluOp = ALU_ADDU;
        w_rLegal = 1'b1;
        case (i_funct)
            FN_ADDU: w_rAluOp = ALU_ADDU;
            FN_ADD:  w_rAluOp = ALU_ADD;
            FN_SUBU: w_rAluOp = ALU_SUBU;
            FN_SUB:  w_rAluOp = ALU_SUB;
            FN_AND:  w_rAluOp = ALU_AND;
            FN_OR:   w_rAluOp = ALU_OR;
            FN_SLT:  w_rAluOp = ALU_SLT;
            FN_SLL:  w_rAluOp = ALU_SLL;
            FN_SRL:  w_rAluOp = ALU_SRL;
            FN_SRA:  w_rAluOp = ALU_SRA;
            default: w_rLegal = 1'b0;
        endcase
    end

    always_comb begin
        o_illegal = 1'b1;
        case (i_op)
            OP_RTYPE: o_illegal = !w_rLegal;
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: o_illegal = 1'b0;
            default: o_illegal = 1'b1;
        endcase
    end

    // lui places the immediate in the upper half, so its extension mode is irrelevant
    always_comb begin
        o_alu_op = ALU_ADDU;
        o_ext_op = 1'b0;
        case (i_state)
            S_DECODE, S_MEM_ADDR: o_ext_op = 1'b1;
            S_EXEC_R: o_alu_op = w_rAluOp;
            S_EXEC_I: begin
                case (i_op)
                    OP_ORI:   o_alu_op = ALU_OR;
                    OP_ADDIU: o_ext_op = 1'b1;
                    OP_SLTI: begin
                        o_alu_op = ALU_SLT;
                        o_ext_op = 1'b1;
                    end
                    OP_LUI:   o_alu_op = ALU_GT0;
                    default:  o_alu_op = ALU_ADDU;
                endcase
            end
            S_BRANCH: o_alu_op = (i_op == OP_BNE) ? ALU_BNE : ALU_EQL;
            default: o_alu_op = ALU_ADDU;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-subset datapath.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions lock into S_TRAP (illegal_o).
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int RESET_STATE_HOLD = 0
)
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [4:0] alu_op,
    output logic [1:0] pc_source,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic [3:0] state_o,
    output logic       illegal_o
`else
    output logic [3:0] state_o
`endif
);

    localparam logic [3:0] HOLD_INIT = 4'(RESET_STATE_HOLD);

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_hold;
    logic [5:0] r_op;
    logic [5:0] r_funct;
    logic [5:0] w_decOp;
    logic [5:0] w_decFunct;
    logic [4:0] w_aluOp;
    logic       w_extOp;
    logic       w_illegal;
    logic       w_holding;

    assign w_holding  = (r_hold != 4'd0);
    // DECODE classifies the live IR fields; later states use the latched copy
    assign w_decOp    = (r_state == S_DECODE) ? op    : r_op;
    assign w_decFunct = (r_state == S_DECODE) ? funct : r_funct;

    mc_alu_dec u_alu_dec (
        .i_state   (r_state),
        .i_op      (w_decOp),
        .i_funct   (w_decFunct),
        .o_alu_op  (w_aluOp),
        .o_ext_op  (w_extOp),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_FETCH;
            r_hold  <= HOLD_INIT;
            r_op    <= '0;
            r_funct <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_FETCH && w_holding) begin
                r_hold <= r_hold - 4'd1;
            end
            if (r_state == S_DECODE) begin
                r_op    <= op;
                r_funct <= funct;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH: begin
                if (!w_holding && mem_ready) w_nextState = S_DECODE;
            end
            S_DECODE: begin
                if (w_illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    w_nextState = S_TRAP;
`else
                    w_nextState = S_FETCH;
`endif
                end else begin
                    case (op)
                        OP_RTYPE:       w_nextState = S_EXEC_R;
                        OP_LW, OP_SW:   w_nextState = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: w_nextState = S_BRANCH;
                        OP_J, OP_JAL:   w_nextState = S_JUMP;
                        default:        w_nextState = S_EXEC_I;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: w_nextState = S_WB_ALU;
            S_MEM_ADDR: w_nextState = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) w_nextState = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (mem_ready) w_nextState = S_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: w_nextState = S_TRAP;
`endif
            default: w_nextState = S_FETCH;
        endcase
    end

    // Outputs are forced idle while reset is asserted so in-flight requests drop at once
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        pc_source  = PCSRC_ALU;
        alu_op     = ALU_ADDU;
        ext_op     = 1'b0;
        if (rstn) begin
            alu_op = w_aluOp;
            ext_op = w_extOp;
            case (r_state)
                S_FETCH: begin
                    alu_src_b = SRCB_FOUR;
                    mem_read  = !w_holding;
                    pc_write  = !w_holding && mem_ready;
                    ir_write  = !w_holding && mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_IMM_SH2;
                S_EXEC_R: alu_src_a = 1'b1;
                S_EXEC_I, S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = (r_op == OP_RTYPE) ? REGDST_RD : REGDST_RT;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    pc_source = PCSRC_ALUOUT;
                    pc_write  = zero;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                    if (r_op == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_R31;
                        mem_to_reg = M2R_PC;
                    end
                end
                default: pc_write = 1'b0;
            endcase
        end
    end

    assign state_o = r_state;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_o = rstn && (r_state == S_TRAP);
`endif

endmodule
